// File: rtl/cache_set.sv
// One set of an N-way set-associative cache.
// Tag match, byte-masked write hit, multi-beat refill and age-based LRU.
module cache_set #(
  parameter int TAG_WIDTH    = 20,
  parameter int OFFSET_WIDTH = 5,
  parameter int WAYS         = 4,
  localparam int WAY_W       = $clog2(WAYS),
  localparam int OW          = OFFSET_WIDTH - 2,
  localparam int WORDS       = 2 ** OW
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [TAG_WIDTH-1:0] tag_i,
  input  logic [OW-1:0]        offset_i,
  input  logic                 read_en_i,
  input  logic                 write_en_i,
  input  logic [3:0]           byte_en_i,
  input  logic [31:0]          write_data_i,
  input  logic                 fill_en_i,
  input  logic                 fill_last_i,
  input  logic [31:0]          fill_data_i,
  output logic                 hit_o,
  output logic [WAY_W-1:0]     hit_way_o,
  output logic [31:0]          read_data_o,
  output logic [WAY_W-1:0]     victim_way_o,
  output logic                 victim_valid_o,
  output logic                 victim_dirty_o,
  output logic [TAG_WIDTH-1:0] victim_tag_o,
  output logic [31:0]          victim_data_o,
  output logic                 fill_busy_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;
  localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);

  logic [0:0]           state_q;
  logic [WAY_W-1:0]     fill_way_q;
  logic [WAYS-1:0]      valid_q;
  logic [WAYS-1:0]      dirty_q;
  logic [TAG_WIDTH-1:0] tag_q [WAYS];
  logic [WAY_W-1:0]     age_q [WAYS];
  logic [WAY_W-1:0]     age_d [WAYS];
  logic [31:0]          data_q [WAYS][WORDS];

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_idle;
  logic [WAY_W-1:0] fill_way;
  logic [WAY_W-1:0] touch_way;
  logic             found;
  logic             idle;
  logic             do_fill;
  logic             do_write;
  logic             touch_fill;
  logic             touch_write;
  logic             touch_read;
  logic             touch;
  logic [31:0]      hit_word;
  logic [31:0]      merged;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (!hit && valid_q[i] && tag_q[i] == tag_i) begin
        hit     = 1'b1;
        hit_way = WAY_W'(i);
      end
    end
  end

  // Invalid ways are preferred; otherwise the oldest line goes.
  always_comb begin
    victim_idle = '0;
    found       = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (age_q[i] == AGE_MAX) victim_idle = WAY_W'(i);
    end
    for (int i = 0; i < WAYS; i++) begin
      if (!found && !valid_q[i]) begin
        victim_idle = WAY_W'(i);
        found       = 1'b1;
      end
    end
  end

  assign idle     = (state_q == IDLE);
  assign fill_way = idle ? victim_idle : fill_way_q;

  assign do_fill     = fill_en_i & (~idle | ~hit);
  assign do_write    = write_en_i & idle & hit & ~fill_en_i;
  assign touch_fill  = do_fill & fill_last_i;
  assign touch_write = do_write;
  assign touch_read  = read_en_i & hit & ~touch_fill & ~do_write
                     & ~(idle & fill_en_i);

  assign hit_word = data_q[hit_way][offset_i];

  always_comb begin
    merged = hit_word;
    for (int b = 0; b < 4; b++) begin
      if (byte_en_i[b]) merged[8*b +: 8] = write_data_i[8*b +: 8];
    end
  end

  always_comb begin
    touch     = 1'b1;
    touch_way = hit_way;
    unique case (1'b1)
      touch_fill:              touch_way = fill_way;
      touch_write, touch_read: touch_way = hit_way;
      default:                 touch     = 1'b0;
    endcase
  end

  always_comb begin
    age_d = age_q;
    if (touch) begin
      for (int i = 0; i < WAYS; i++) begin
        if (WAY_W'(i) == touch_way)
          age_d[i] = '0;
        else if (age_q[i] < age_q[touch_way])
          age_d[i] = age_q[i] + WAY_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      fill_way_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      for (int i = 0; i < WAYS; i++) begin
        tag_q[i] <= '0;
        age_q[i] <= WAY_W'(i);
      end
    end else begin
      age_q <= age_d;
      if (do_fill) begin
        if (idle) begin
          tag_q[fill_way]   <= tag_i;
          dirty_q[fill_way] <= 1'b0;
          fill_way_q        <= fill_way;
        end
        valid_q[fill_way] <= fill_last_i;
        state_q           <= fill_last_i ? IDLE : FILL;
      end else if (do_write) begin
        dirty_q[hit_way] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_fill)
      data_q[fill_way][offset_i] <= fill_data_i;
    else if (do_write)
      data_q[hit_way][offset_i] <= merged;
  end

  assign hit_o          = hit;
  assign hit_way_o      = hit_way;
  assign read_data_o    = hit ? hit_word : '0;
  assign victim_way_o   = fill_way;
  assign victim_valid_o = valid_q[fill_way];
  assign victim_dirty_o = dirty_q[fill_way];
  assign victim_tag_o   = tag_q[fill_way];
  assign victim_data_o  = data_q[fill_way][offset_i];
  assign fill_busy_o    = ~idle;

endmodule

// File: tb/tb_cache_set.sv
// Directed bench for cache_set: fill, byte write, LRU,
// collisions, read miss and reset during a refill.
module tb_cache_set;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [19:0] tag_i;
  logic [2:0]  offset_i;
  logic        read_en_i;
  logic        write_en_i;
  logic [3:0]  byte_en_i;
  logic [31:0] write_data_i;
  logic        fill_en_i;
  logic        fill_last_i;
  logic [31:0] fill_data_i;
  logic        hit_o;
  logic [1:0]  hit_way_o;
  logic [31:0] read_data_o;
  logic [1:0]  victim_way_o;
  logic        victim_valid_o;
  logic        victim_dirty_o;
  logic [19:0] victim_tag_o;
  logic [31:0] victim_data_o;
  logic        fill_busy_o;

  int errors = 0;
  int checks = 0;

  localparam logic [19:0] T0 = 20'h12345;
  localparam logic [19:0] T1 = 20'h00111;
  localparam logic [19:0] T2 = 20'h00222;
  localparam logic [19:0] T3 = 20'h00333;
  localparam logic [19:0] T4 = 20'h00444;
  localparam logic [19:0] T5 = 20'h00555;
  localparam logic [19:0] T6 = 20'h00666;
  localparam logic [19:0] T7 = 20'h00777;
  localparam logic [19:0] TM = 20'h77777;

  cache_set dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .tag_i          (tag_i),
    .offset_i       (offset_i),
    .read_en_i      (read_en_i),
    .write_en_i     (write_en_i),
    .byte_en_i      (byte_en_i),
    .write_data_i   (write_data_i),
    .fill_en_i      (fill_en_i),
    .fill_last_i    (fill_last_i),
    .fill_data_i    (fill_data_i),
    .hit_o          (hit_o),
    .hit_way_o      (hit_way_o),
    .read_data_o    (read_data_o),
    .victim_way_o   (victim_way_o),
    .victim_valid_o (victim_valid_o),
    .victim_dirty_o (victim_dirty_o),
    .victim_tag_o   (victim_tag_o),
    .victim_data_o  (victim_data_o),
    .fill_busy_o    (fill_busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic quiet();
    read_en_i    = 1'b0;
    write_en_i   = 1'b0;
    byte_en_i    = 4'h0;
    write_data_i = '0;
    fill_en_i    = 1'b0;
    fill_last_i  = 1'b0;
    fill_data_i  = '0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fill_line(input logic [19:0] t, input logic [31:0] base);
    for (int b = 0; b < 8; b++) begin
      tag_i       = t;
      offset_i    = 3'(b);
      fill_en_i   = 1'b1;
      fill_last_i = (b == 7);
      fill_data_i = base + 32'(b);
      step();
    end
    quiet();
  endtask

  task automatic test_reset();
    quiet();
    tag_i    = T0;
    offset_i = 3'd0;
    rst_ni   = 1'b0;
    #3;
    if (hit_o !== 1'b0) begin
      errors++; $display("FAIL rst_hit: got %b want 0", hit_o);
    end
    checks++;
    if (hit_way_o !== 2'd0) begin
      errors++; $display("FAIL rst_hit_way: got %0d want 0", hit_way_o);
    end
    checks++;
    if (read_data_o !== 32'h0) begin
      errors++; $display("FAIL rst_rdata: got %h want 0", read_data_o);
    end
    checks++;
    if (victim_way_o !== 2'd0 || victim_valid_o !== 1'b0 ||
        victim_dirty_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_victim: way=%0d v=%b d=%b want 0 0 0",
               victim_way_o, victim_valid_o, victim_dirty_o);
    end
    checks++;
    if (victim_tag_o !== 20'h0) begin
      errors++; $display("FAIL rst_vtag: got %h want 0", victim_tag_o);
    end
    checks++;
    if (fill_busy_o !== 1'b0) begin
      errors++; $display("FAIL rst_busy: got %b want 0", fill_busy_o);
    end
    checks++;
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    step();
  endtask

  task automatic test_cold_fill();
    int busy_cnt;
    busy_cnt = 0;
    for (int b = 0; b < 8; b++) begin
      tag_i       = T0;
      offset_i    = 3'(b);
      fill_en_i   = 1'b1;
      fill_last_i = (b == 7);
      fill_data_i = 32'hA0 + 32'(b);
      step();
      if (fill_busy_o) busy_cnt++;
      if (b == 2) begin
        if (hit_o !== 1'b0) begin
          errors++; $display("FAIL fill_mid_hit: got %b want 0", hit_o);
        end
        checks++;
      end
    end
    quiet();
    if (busy_cnt != 7) begin
      errors++; $display("FAIL fill_busy_cycles: got %0d want 7", busy_cnt);
    end
    checks++;
    tag_i     = T0;
    offset_i  = 3'd3;
    read_en_i = 1'b1;
    #1;
    if (hit_o !== 1'b1 || hit_way_o !== 2'd0 || read_data_o !== 32'hA3) begin
      errors++;
      $display("FAIL cold_read: hit=%b way=%0d data=%h want 1 0 000000a3",
               hit_o, hit_way_o, read_data_o);
    end
    checks++;
    step();
    quiet();
  endtask

  task automatic test_byte_write();
    tag_i        = T0;
    offset_i     = 3'd3;
    write_en_i   = 1'b1;
    byte_en_i    = 4'hF;
    write_data_i = 32'h11223344;
    step();
    byte_en_i    = 4'b0101;
    write_data_i = 32'hAABBCCDD;
    step();
    quiet();
    #1;
    if (read_data_o !== 32'h11BB33DD) begin
      errors++; $display("FAIL byte_write: got %h want 11bb33dd", read_data_o);
    end
    checks++;
    fill_line(T1, 32'h100);
    fill_line(T2, 32'h200);
    fill_line(T3, 32'h300);
    tag_i    = TM;
    offset_i = 3'd3;
    #1;
    if (victim_way_o !== 2'd0 || victim_dirty_o !== 1'b1 ||
        victim_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL dirty_victim: way=%0d d=%b v=%b want 0 1 1",
               victim_way_o, victim_dirty_o, victim_valid_o);
    end
    checks++;
    if (victim_tag_o !== T0 || victim_data_o !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL victim_line: tag=%h data=%h want 12345 11bb33dd",
               victim_tag_o, victim_data_o);
    end
    checks++;
  endtask

  task automatic test_lru();
    tag_i     = T0;
    offset_i  = 3'd0;
    read_en_i = 1'b1;
    step();
    quiet();
    #1;
    if (victim_way_o !== 2'd1 || victim_dirty_o !== 1'b0) begin
      errors++;
      $display("FAIL lru_victim: way=%0d d=%b want 1 0",
               victim_way_o, victim_dirty_o);
    end
    checks++;
    fill_line(T4, 32'h400);
    tag_i    = T4;
    offset_i = 3'd6;
    #1;
    if (hit_o !== 1'b1 || hit_way_o !== 2'd1 || read_data_o !== 32'h406) begin
      errors++;
      $display("FAIL lru_t4: hit=%b way=%0d data=%h want 1 1 00000406",
               hit_o, hit_way_o, read_data_o);
    end
    checks++;
    tag_i = T1;
    #1;
    if (hit_o !== 1'b0) begin
      errors++; $display("FAIL lru_t1_evicted: hit=%b want 0", hit_o);
    end
    checks++;
    tag_i    = T0;
    offset_i = 3'd3;
    #1;
    if (hit_o !== 1'b1 || hit_way_o !== 2'd0 || read_data_o !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL lru_t0_kept: hit=%b way=%0d data=%h", hit_o, hit_way_o,
               read_data_o);
    end
    checks++;
  endtask

  task automatic test_single_beat();
    tag_i       = T5;
    offset_i    = 3'd0;
    fill_en_i   = 1'b1;
    fill_last_i = 1'b1;
    fill_data_i = 32'h55;
    step();
    quiet();
    #1;
    if (fill_busy_o !== 1'b0) begin
      errors++; $display("FAIL single_busy: got %b want 0", fill_busy_o);
    end
    checks++;
    if (hit_o !== 1'b1 || hit_way_o !== 2'd2 || read_data_o !== 32'h55) begin
      errors++;
      $display("FAIL single_hit: hit=%b way=%0d data=%h want 1 2 00000055",
               hit_o, hit_way_o, read_data_o);
    end
    checks++;
    if (victim_way_o !== 2'd3) begin
      errors++; $display("FAIL single_victim: got %0d want 3", victim_way_o);
    end
    checks++;
  endtask

  task automatic test_collision();
    for (int b = 0; b < 8; b++) begin
      tag_i        = T6;
      offset_i     = 3'(b);
      fill_en_i    = 1'b1;
      fill_last_i  = (b == 7);
      fill_data_i  = 32'h600 + 32'(b);
      write_en_i   = 1'b1;
      byte_en_i    = 4'hF;
      write_data_i = 32'hDEADBEEF;
      step();
    end
    quiet();
    tag_i    = T6;
    offset_i = 3'd0;
    #1;
    if (hit_way_o !== 2'd3 || read_data_o !== 32'h600) begin
      errors++;
      $display("FAIL coll_w0: way=%0d data=%h want 3 00000600",
               hit_way_o, read_data_o);
    end
    checks++;
    offset_i = 3'd5;
    #1;
    if (read_data_o !== 32'h605) begin
      errors++; $display("FAIL coll_w5: got %h want 00000605", read_data_o);
    end
    checks++;
    tag_i        = TM;
    offset_i     = 3'd3;
    write_en_i   = 1'b1;
    byte_en_i    = 4'hF;
    write_data_i = 32'h0;
    step();
    quiet();
    #1;
    if (victim_way_o !== 2'd0 || victim_dirty_o !== 1'b1 ||
        victim_tag_o !== T0) begin
      errors++;
      $display("FAIL write_miss: way=%0d d=%b tag=%h want 0 1 12345",
               victim_way_o, victim_dirty_o, victim_tag_o);
    end
    checks++;
    read_en_i = 1'b1;
    tag_i     = T0;
    step();
    tag_i     = T4;
    step();
    tag_i     = T5;
    step();
    quiet();
    #1;
    if (victim_way_o !== 2'd3 || victim_dirty_o !== 1'b0 ||
        victim_tag_o !== T6) begin
      errors++;
      $display("FAIL coll_clean: way=%0d d=%b tag=%h want 3 0 00666",
               victim_way_o, victim_dirty_o, victim_tag_o);
    end
    checks++;
  endtask

  task automatic test_read_miss();
    tag_i     = TM;
    offset_i  = 3'd1;
    read_en_i = 1'b1;
    #1;
    if (hit_o !== 1'b0 || hit_way_o !== 2'd0 || read_data_o !== 32'h0) begin
      errors++;
      $display("FAIL read_miss: hit=%b way=%0d data=%h want 0 0 0",
               hit_o, hit_way_o, read_data_o);
    end
    checks++;
    step();
    quiet();
    #1;
    if (victim_way_o !== 2'd3) begin
      errors++; $display("FAIL read_miss_lru: got %0d want 3", victim_way_o);
    end
    checks++;
  endtask

  task automatic test_reset_mid_fill();
    logic [19:0] tags [8];
    tags = '{T0, T1, T2, T3, T4, T5, T6, T7};
    for (int b = 0; b < 4; b++) begin
      tag_i       = T7;
      offset_i    = 3'(b);
      fill_en_i   = 1'b1;
      fill_last_i = 1'b0;
      fill_data_i = 32'h700 + 32'(b);
      step();
    end
    offset_i    = 3'd4;
    fill_data_i = 32'h704;
    #1;
    if (fill_busy_o !== 1'b1) begin
      errors++; $display("FAIL mid_busy: got %b want 1", fill_busy_o);
    end
    checks++;
    rst_ni = 1'b0;
    #1;
    quiet();
    if (fill_busy_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_busy: got %b want 0", fill_busy_o);
    end
    checks++;
    for (int i = 0; i < 8; i++) begin
      tag_i = tags[i];
      #0.5;
      if (hit_o !== 1'b0) begin
        errors++; $display("FAIL rst_mid_miss: tag=%h hit=%b want 0",
                           tags[i], hit_o);
      end
      checks++;
    end
    rst_ni = 1'b1;
    step();
    #1;
    if (victim_way_o !== 2'd0 || victim_valid_o !== 1'b0 ||
        fill_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_victim: way=%0d v=%b busy=%b want 0 0 0",
               victim_way_o, victim_valid_o, fill_busy_o);
    end
    checks++;
  endtask

  initial begin
    rst_ni   = 1'b0;
    tag_i    = '0;
    offset_i = '0;
    quiet();
    test_reset();
    test_cold_fill();
    test_byte_write();
    test_lru();
    test_single_beat();
    test_collision();
    test_read_miss();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_set.md
CACHE_SET -- requirements
Module: cache_set

Interface
REQ-001 SHALL provide parameter TAG_WIDTH, default 20, meaning tag bits per line.
REQ-002 SHALL provide parameter OFFSET_WIDTH, default 5, meaning byte-offset bits; words per line = 2**(OFFSET_WIDTH-2).
REQ-003 SHALL provide parameter WAYS, default 4, meaning associativity; power of two and at least 2; WAY_W = clog2(WAYS).
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port tag_i, input, TAG_WIDTH, lookup/allocate tag.
REQ-007 SHALL have port offset_i, input, OFFSET_WIDTH-2, word index for read, write, fill and victim read.
REQ-008 SHALL have port read_en_i, input, 1, read access; an access with hit touches LRU.
REQ-009 SHALL have ports write_en_i (1), byte_en_i (4) and write_data_i (32), all inputs, for a byte-masked word write on hit.
REQ-010 SHALL have ports fill_en_i (1), fill_last_i (1) and fill_data_i (32), all inputs, for refill word beats.
REQ-011 SHALL have outputs hit_o (1), hit_way_o (WAY_W) and read_data_o (32), giving lookup result and hit word.
REQ-012 SHALL have outputs victim_way_o (WAY_W), victim_valid_o (1), victim_dirty_o (1), victim_tag_o (TAG_WIDTH) and victim_data_o (32), giving replacement candidate state and its word at offset_i.
REQ-013 SHALL have output fill_busy_o, 1, high while in FILL.

Function
REQ-014 SHALL hold per way: valid, dirty, tag, data array of words-per-line x 32, and an age counter of WAY_W bits.
REQ-015 SHALL drive hit_o combinationally: high iff some way is valid with tag equal to tag_i; hit_way_o is that way, else 0.
REQ-016 SHALL drive read_data_o as the hit way's word at offset_i when hit_o=1, else 0.
REQ-017 SHALL select the victim in IDLE as the lowest-index invalid way; if all ways are valid, the way with age WAYS-1.
REQ-018 SHALL drive victim_way_o from the latched fill way while in FILL.
REQ-019 SHALL drive victim_valid_o, victim_dirty_o, victim_tag_o and victim_data_o combinationally from the selected victim way.
REQ-020 SHALL implement FSM with states IDLE and FILL; reset state IDLE.
REQ-021 In IDLE with fill_en_i=1 and hit_o=0: SHALL latch the victim way, write tag_i to it, clear its valid and dirty bits, write fill_data_i at offset_i, and enter FILL.
REQ-022 In FILL, each fill_en_i=1 cycle SHALL write fill_data_i at offset_i of the latched way.
REQ-023 A fill beat with fill_last_i=1 (in IDLE or FILL) SHALL set valid=1, keep dirty=0, touch LRU for that way, and go to or stay in IDLE.
REQ-024 A single-beat fill (fill_en_i=1 and fill_last_i=1 in IDLE) SHALL complete in one cycle.
REQ-025 fill_en_i=1 in IDLE with hit_o=1 SHALL be ignored, with no state change.
REQ-026 write_en_i=1 in IDLE with hit_o=1 SHALL update only the bytes whose byte_en_i bit is set, set dirty=1, and touch LRU.
REQ-027 A write miss, or any write_en_i during FILL, SHALL be ignored.
REQ-028 read_en_i=1 with hit_o=1 SHALL touch LRU; a read miss SHALL change no state.
REQ-029 An LRU touch of way w with old age a SHALL set age[w]=0 and increment every age below a; ages SHALL stay a permutation of 0..WAYS-1.
REQ-030 With simultaneous fill_en_i and write_en_i, the fill SHALL win and the write SHALL be dropped; at most one LRU touch SHALL occur per cycle, with priority fill, write, read.
REQ-031 Lookups during FILL SHALL hit other valid ways normally; the latched way SHALL not hit until its fill completes.

Reset
REQ-032 Asserting rst_ni=0 at any time, including mid-FILL, SHALL immediately clear valid, dirty and tag, set age[w]=w, and force IDLE; data words need not be cleared.
REQ-033 Output values during and after reset SHALL be: hit_o=0, hit_way_o=0, read_data_o=0, victim_way_o=0, victim_valid_o=0, victim_dirty_o=0, victim_tag_o=0, fill_busy_o=0; victim_data_o is unspecified.

Verification
REQ-034 SHALL verify cold fill: after reset, tag 0x12345 filled over 8 beats with data 0xA0..0xA7 -> fill_busy_o high for 7 cycles, then a read at offset 3 gives hit_o=1, hit_way_o=0, read_data_o=0xA3.
REQ-035 SHALL verify byte write: hit word 0x11223344 written with byte_en_i=0b0101 and data 0xAABBCCDD -> read gives 0x11BB33DD, and victim_dirty_o=1 when that way is the victim.
REQ-036 SHALL verify LRU: fill tags T0..T3, then read T0 -> victim_way_o=1; filling T4 replaces way 1, and T1 then misses.
REQ-037 SHALL verify reset mid-FILL: rst_ni low at beat 4 -> fill_busy_o=0 and every tag misses; next victim_way_o=0.
REQ-038 SHALL verify collisions: fill_en_i and write_en_i in the same cycle -> only fill data is stored; write miss -> dirty and age state unchanged.
